// File: rtl/uart_boot_loader.sv
// uart_boot_loader
//   Holds the core in reset while a framed program image arrives over UART.
//   Frame: MAGIC, LEN[4], ADDR[4], LEN*4 payload bytes, CSUM (XOR of payload).
//   LEN and ADDR are sent LSB first. When LEN is zero the frame carries no
//   ADDR field, so CSUM follows LEN directly.
//   Payload bytes are packed little-endian into 32-bit words and written to
//   RAM through a req/gnt handshake. The block answers with ACK_BYTE or
//   NAK_BYTE and releases the core once a frame has been verified.
//
// Ports
//   clk_i, rst_i          clock, asynchronous active-high reset
//   rx_valid_i/rx_data_i  received byte strobe and data
//   bus_req_o/bus_gnt_i   write request and grant
//   bus_we_o              write enable, mirrors bus_req_o
//   bus_addr_o/bus_data_o word-aligned address and write data
//   bus_hb_o              access size, always HB_WORD
//   tx_valid_o/tx_data_o  response byte, held until tx_ready_i
//   core_hold_o           1 keeps the core in reset
//   boot_done_o           sticky: image loaded and verified
//   boot_err_o            sticky: at least one frame rejected
module uart_boot_loader #(
  parameter logic [7:0]  MAGIC     = 8'hA5,
  parameter logic [31:0] MAX_WORDS = 32'h0002_0000,
  parameter logic [7:0]  ACK_BYTE  = 8'h06,
  parameter logic [7:0]  NAK_BYTE  = 8'h15,
  parameter logic [1:0]  HB_WORD   = 2'b00
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        rx_valid_i,
  input  logic [7:0]  rx_data_i,
  output logic        bus_req_o,
  input  logic        bus_gnt_i,
  output logic        bus_we_o,
  output logic [31:0] bus_addr_o,
  output logic [31:0] bus_data_o,
  output logic [1:0]  bus_hb_o,
  output logic        tx_valid_o,
  output logic [7:0]  tx_data_o,
  input  logic        tx_ready_i,
  output logic        core_hold_o,
  output logic        boot_done_o,
  output logic        boot_err_o
);

  typedef enum logic [3:0] {
    IDLE, LEN, ADDR, DATA, WRITE, CSUM, RESP_ACK, RESP_NAK, DONE
  } state_t;

  state_t      state_q, state_d;
  logic [1:0]  cnt_q, cnt_d;
  logic [23:0] field_q, field_d;
  logic [31:0] words_q, words_d;
  logic [31:0] addr_q, addr_d;
  logic [31:0] data_q, data_d;
  logic [7:0]  csum_q, csum_d;
  logic [7:0]  skid_q, skid_d;
  logic        skid_vld_q, skid_vld_d;
  logic        ovr_q, ovr_d;
  logic        req_q, req_d;
  logic        tx_vld_q, tx_vld_d;
  logic [7:0]  tx_q, tx_d;
  logic        hold_q, hold_d;
  logic        done_q, done_d;
  logic        err_q, err_d;

  // LEN/ADDR shift in LSB first; the 4th byte completes the field.
  logic [31:0] field_full;
  // In DATA/CSUM a byte parked in the skid register takes priority over rx.
  logic        byte_vld;
  logic [7:0]  byte_in;

  assign field_full = {rx_data_i, field_q};
  assign byte_vld   = skid_vld_q | rx_valid_i;
  assign byte_in    = skid_vld_q ? skid_q : rx_data_i;

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q    <= IDLE;
      cnt_q      <= '0;
      field_q    <= '0;
      words_q    <= '0;
      addr_q     <= '0;
      data_q     <= '0;
      csum_q     <= '0;
      skid_q     <= '0;
      skid_vld_q <= 1'b0;
      ovr_q      <= 1'b0;
      req_q      <= 1'b0;
      tx_vld_q   <= 1'b0;
      tx_q       <= '0;
      hold_q     <= 1'b1;
      done_q     <= 1'b0;
      err_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      field_q    <= field_d;
      words_q    <= words_d;
      addr_q     <= addr_d;
      data_q     <= data_d;
      csum_q     <= csum_d;
      skid_q     <= skid_d;
      skid_vld_q <= skid_vld_d;
      ovr_q      <= ovr_d;
      req_q      <= req_d;
      tx_vld_q   <= tx_vld_d;
      tx_q       <= tx_d;
      hold_q     <= hold_d;
      done_q     <= done_d;
      err_q      <= err_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    field_d    = field_q;
    words_d    = words_q;
    addr_d     = addr_q;
    data_d     = data_q;
    csum_d     = csum_q;
    skid_d     = skid_q;
    skid_vld_d = skid_vld_q;
    ovr_d      = ovr_q;
    req_d      = req_q;
    tx_vld_d   = tx_vld_q;
    tx_d       = tx_q;
    hold_d     = hold_q;
    done_d     = done_q;
    err_d      = err_q;

    case (state_q)
      IDLE: begin
        if (rx_valid_i && rx_data_i == MAGIC) begin
          state_d = LEN;
          cnt_d   = '0;
          csum_d  = '0;
        end
      end

      LEN: begin
        if (rx_valid_i) begin
          field_d = {rx_data_i, field_q[23:8]};
          cnt_d   = cnt_q + 2'd1;
          if (cnt_q == 2'd3) begin
            words_d = field_full;
            if (field_full > MAX_WORDS) begin
              state_d  = RESP_NAK;
              tx_vld_d = 1'b1;
              tx_d     = NAK_BYTE;
            end else if (field_full == '0) begin
              state_d = CSUM;
            end else begin
              state_d = ADDR;
            end
          end
        end
      end

      ADDR: begin
        if (rx_valid_i) begin
          field_d = {rx_data_i, field_q[23:8]};
          cnt_d   = cnt_q + 2'd1;
          if (cnt_q == 2'd3) begin
            if (field_full[1:0] != 2'b00) begin
              state_d  = RESP_NAK;
              tx_vld_d = 1'b1;
              tx_d     = NAK_BYTE;
            end else begin
              state_d = DATA;
              addr_d  = field_full;
            end
          end
        end
      end

      DATA: begin
        if (byte_vld) begin
          // Consuming the skid byte frees the slot for a byte arriving now.
          if (skid_vld_q) begin
            skid_vld_d = rx_valid_i;
            if (rx_valid_i) skid_d = rx_data_i;
          end
          data_d[{cnt_q, 3'b000} +: 8] = byte_in;
          csum_d = csum_q ^ byte_in;
          cnt_d  = cnt_q + 2'd1;
          if (cnt_q == 2'd3) begin
            state_d = WRITE;
            req_d   = 1'b1;
          end
        end
      end

      WRITE: begin
        if (rx_valid_i) begin
          if (skid_vld_q) begin
            ovr_d = 1'b1;
          end else begin
            skid_vld_d = 1'b1;
            skid_d     = rx_data_i;
          end
        end
        if (bus_gnt_i) begin
          req_d   = 1'b0;
          addr_d  = addr_q + 32'd4;
          words_d = words_q - 32'd1;
          if (ovr_d) begin
            state_d  = RESP_NAK;
            tx_vld_d = 1'b1;
            tx_d     = NAK_BYTE;
          end else if (words_q == 32'd1) begin
            state_d = CSUM;
          end else begin
            state_d = DATA;
          end
        end
      end

      CSUM: begin
        if (byte_vld) begin
          skid_vld_d = 1'b0;
          tx_vld_d   = 1'b1;
          if (byte_in == csum_q) begin
            state_d = RESP_ACK;
            tx_d    = ACK_BYTE;
          end else begin
            state_d = RESP_NAK;
            tx_d    = NAK_BYTE;
          end
        end
      end

      RESP_ACK: begin
        if (tx_ready_i) begin
          tx_vld_d = 1'b0;
          state_d  = DONE;
          done_d   = 1'b1;
          hold_d   = 1'b0;
        end
      end

      RESP_NAK: begin
        if (tx_ready_i) begin
          tx_vld_d   = 1'b0;
          state_d    = IDLE;
          err_d      = 1'b1;
          cnt_d      = '0;
          field_d    = '0;
          words_d    = '0;
          csum_d     = '0;
          skid_d     = '0;
          skid_vld_d = 1'b0;
          ovr_d      = 1'b0;
        end
      end

      DONE: ;

      default: state_d = IDLE;
    endcase
  end

  assign bus_req_o   = req_q;
  assign bus_we_o    = req_q;
  assign bus_addr_o  = addr_q;
  assign bus_data_o  = data_q;
  assign bus_hb_o    = HB_WORD;
  assign tx_valid_o  = tx_vld_q;
  assign tx_data_o   = tx_q;
  assign core_hold_o = hold_q;
  assign boot_done_o = done_q;
  assign boot_err_o  = err_q;

endmodule

// File: tb/tb_uart_boot_loader.sv
module tb_uart_boot_loader;

  logic        clk_i = 1'b0;
  logic        rst_i = 1'b1;
  logic        rx_valid_i = 1'b0;
  logic [7:0]  rx_data_i = 8'h00;
  logic        bus_req_o;
  logic        bus_gnt_i = 1'b0;
  logic        bus_we_o;
  logic [31:0] bus_addr_o;
  logic [31:0] bus_data_o;
  logic [1:0]  bus_hb_o;
  logic        tx_valid_o;
  logic [7:0]  tx_data_o;
  logic        tx_ready_i = 1'b0;
  logic        core_hold_o;
  logic        boot_done_o;
  logic        boot_err_o;

  uart_boot_loader dut (
    .clk_i(clk_i), .rst_i(rst_i),
    .rx_valid_i(rx_valid_i), .rx_data_i(rx_data_i),
    .bus_req_o(bus_req_o), .bus_gnt_i(bus_gnt_i), .bus_we_o(bus_we_o),
    .bus_addr_o(bus_addr_o), .bus_data_o(bus_data_o), .bus_hb_o(bus_hb_o),
    .tx_valid_o(tx_valid_o), .tx_data_o(tx_data_o), .tx_ready_i(tx_ready_i),
    .core_hold_o(core_hold_o), .boot_done_o(boot_done_o), .boot_err_o(boot_err_o)
  );

  always #5 clk_i = ~clk_i;

  int n_tests = 0;
  int n_fail  = 0;

  // payload 11 22 .. 88: XOR of all bytes is 0x88
  localparam logic [63:0] PL8     = 64'h8877665544332211;
  localparam logic [7:0]  CSUM_OK = 8'h88;

  // Bus slave: grants gnt_delay cycles after req rises, logs writes and
  // counts any change of addr/data/we/hb while a request waits.
  int          gnt_delay = 1;
  int          wait_cnt = 0;
  int          wr_n = 0;
  int          req_cycles = 0;
  int          last_req_len = 0;
  int          stable_bad = 0;
  logic [31:0] hold_addr, hold_data;
  logic [31:0] wr_addr [16];
  logic [31:0] wr_data [16];

  always @(negedge clk_i) begin
    if (rst_i || !bus_req_o) begin
      bus_gnt_i = 1'b0;
      wait_cnt  = 0;
    end else if (bus_gnt_i) begin
      bus_gnt_i = 1'b0;
      wait_cnt  = 0;
    end else begin
      req_cycles++;
      if (bus_we_o !== 1'b1 || bus_hb_o !== 2'b00) stable_bad++;
      if (wait_cnt == 0) begin
        hold_addr = bus_addr_o;
        hold_data = bus_data_o;
      end else if (bus_addr_o !== hold_addr || bus_data_o !== hold_data) begin
        stable_bad++;
      end
      if (wait_cnt >= gnt_delay) begin
        bus_gnt_i = 1'b1;
        if (wr_n < 16) begin
          wr_addr[wr_n] = bus_addr_o;
          wr_data[wr_n] = bus_data_o;
        end
        wr_n++;
        last_req_len = wait_cnt + 1;
      end else begin
        wait_cnt++;
      end
    end
  end

  task automatic clear_mon();
    wr_n = 0; req_cycles = 0; stable_bad = 0; last_req_len = 0;
  endtask

  task automatic do_reset();
    @(negedge clk_i);
    rst_i = 1'b1;
    rx_valid_i = 1'b0;
    tx_ready_i = 1'b0;
    repeat (2) @(negedge clk_i);
    rst_i = 1'b0;
    clear_mon();
    @(negedge clk_i);
  endtask

  task automatic send_byte(input logic [7:0] b, input int gap);
    rx_valid_i = 1'b1;
    rx_data_i  = b;
    @(negedge clk_i);
    rx_valid_i = 1'b0;
    repeat (gap) @(negedge clk_i);
  endtask

  task automatic send_frame(input logic [31:0] len, input logic [31:0] addr,
                            input int n, input logic [63:0] pl,
                            input logic [7:0] cs, input int gap, input bit send_cs);
    send_byte(8'hA5, gap);
    for (int i = 0; i < 4; i++) send_byte(len[8*i +: 8], gap);
    for (int i = 0; i < 4; i++) send_byte(addr[8*i +: 8], gap);
    for (int i = 0; i < n; i++) send_byte(pl[8*i +: 8], gap);
    if (send_cs) send_byte(cs, gap);
  endtask

  // Waits (bounded) for a response byte, optionally stalls tx_ready_i, then
  // completes the handshake. Returns at the negedge after the accepting edge.
  task automatic get_tx(input int rdy_dly, output logic [7:0] b,
                        output int waited, output bit held);
    waited = 0; held = 1'b1; b = 8'h00;
    while (tx_valid_o !== 1'b1 && waited < 3000) begin
      @(negedge clk_i);
      waited++;
    end
    if (tx_valid_o !== 1'b1) begin
      waited = -1;
      return;
    end
    b = tx_data_o;
    repeat (rdy_dly) begin
      @(negedge clk_i);
      if (tx_valid_o !== 1'b1 || tx_data_o !== b) held = 1'b0;
    end
    tx_ready_i = 1'b1;
    @(negedge clk_i);
    tx_ready_i = 1'b0;
  endtask

  task automatic test_reset();
    n_tests++; if ({bus_req_o, bus_we_o, bus_hb_o, tx_valid_o} !== 5'b0) begin n_fail++; $display("FAIL reset_ctl: got %b want 00000", {bus_req_o, bus_we_o, bus_hb_o, tx_valid_o}); end
    n_tests++; if ({bus_addr_o, bus_data_o, tx_data_o} !== 72'h0) begin n_fail++; $display("FAIL reset_data: got %h want 0", {bus_addr_o, bus_data_o, tx_data_o}); end
    n_tests++; if ({core_hold_o, boot_done_o, boot_err_o} !== 3'b100) begin n_fail++; $display("FAIL reset_status: got %b want 100", {core_hold_o, boot_done_o, boot_err_o}); end
  endtask

  task automatic test_basic_load();
    logic [7:0] b; int w; bit h;
    do_reset();
    gnt_delay = 1;
    send_frame(32'd2, 32'h0008_0000, 8, PL8, CSUM_OK, 3, 1'b1);
    while (tx_valid_o !== 1'b1 && req_cycles < 3000) @(negedge clk_i);
    n_tests++; if ({core_hold_o, boot_done_o} !== 2'b10) begin n_fail++; $display("FAIL basic_pre_ack: hold/done got %b want 10", {core_hold_o, boot_done_o}); end
    get_tx(0, b, w, h);
    n_tests++; if (b !== 8'h06) begin n_fail++; $display("FAIL basic_tx: got %h want 06 (waited %0d)", b, w); end
    n_tests++; if ({core_hold_o, boot_done_o, tx_valid_o} !== 3'b010) begin n_fail++; $display("FAIL basic_release: hold/done/txv got %b want 010", {core_hold_o, boot_done_o, tx_valid_o}); end
    n_tests++; if (wr_n !== 2) begin n_fail++; $display("FAIL basic_wr_n: got %0d want 2", wr_n); end
    n_tests++; if (wr_addr[0] !== 32'h0008_0000 || wr_data[0] !== 32'h4433_2211) begin n_fail++; $display("FAIL basic_wr0: got %h@%h want 44332211@00080000", wr_data[0], wr_addr[0]); end
    n_tests++; if (wr_addr[1] !== 32'h0008_0004 || wr_data[1] !== 32'h8877_6655) begin n_fail++; $display("FAIL basic_wr1: got %h@%h want 88776655@00080004", wr_data[1], wr_addr[1]); end
    n_tests++; if (last_req_len !== 2 || stable_bad !== 0) begin n_fail++; $display("FAIL basic_req_shape: len %0d unstable %0d want 2 0", last_req_len, stable_bad); end
    // DONE ignores any further frame
    send_frame(32'd1, 32'h0, 4, PL8, 8'h44, 3, 1'b1);
    repeat (5) @(negedge clk_i);
    n_tests++; if (wr_n !== 2 || tx_valid_o !== 1'b0) begin n_fail++; $display("FAIL done_ignores: wr_n %0d txv %b want 2 0", wr_n, tx_valid_o); end
  endtask

  task automatic test_bad_csum();
    logic [7:0] b; int w; bit h;
    do_reset();
    gnt_delay = 1;
    send_frame(32'd2, 32'h0008_0000, 8, PL8, 8'h09, 3, 1'b1);
    get_tx(0, b, w, h);
    n_tests++; if (b !== 8'h15) begin n_fail++; $display("FAIL badcs_tx: got %h want 15", b); end
    n_tests++; if (wr_n !== 2) begin n_fail++; $display("FAIL badcs_wr_n: got %0d want 2", wr_n); end
    n_tests++; if ({core_hold_o, boot_done_o, boot_err_o} !== 3'b101) begin n_fail++; $display("FAIL badcs_status: got %b want 101", {core_hold_o, boot_done_o, boot_err_o}); end
    send_frame(32'd2, 32'h0008_0000, 8, PL8, CSUM_OK, 3, 1'b1);
    get_tx(0, b, w, h);
    n_tests++; if (b !== 8'h06) begin n_fail++; $display("FAIL resend_tx: got %h want 06", b); end
    n_tests++; if ({core_hold_o, boot_done_o, boot_err_o, wr_n} !== {3'b011, 32'd4}) begin n_fail++; $display("FAIL resend_status: got %b wr_n %0d want 011 4", {core_hold_o, boot_done_o, boot_err_o}, wr_n); end
    n_tests++; if (wr_data[3] !== 32'h8877_6655 || wr_addr[3] !== 32'h0008_0004) begin n_fail++; $display("FAIL resend_wr: got %h@%h want 88776655@00080004", wr_data[3], wr_addr[3]); end
  endtask

  task automatic test_len_addr_errors();
    logic [7:0] b; int w; bit h;
    do_reset();
    send_byte(8'hA5, 3); send_byte(8'h00, 3); send_byte(8'h02, 3); send_byte(8'h00, 3); send_byte(8'h01, 0);
    get_tx(0, b, w, h);
    n_tests++; if (b !== 8'h15 || w !== 0) begin n_fail++; $display("FAIL len_big: got %h after %0d want 15 after 0", b, w); end
    send_byte(8'hA5, 3); send_byte(8'h01, 3); send_byte(8'h00, 3); send_byte(8'h02, 3); send_byte(8'h00, 0);
    get_tx(0, b, w, h);
    n_tests++; if (b !== 8'h15 || w !== 0) begin n_fail++; $display("FAIL len_max_plus1: got %h after %0d want 15 after 0", b, w); end
    send_byte(8'hA5, 3); send_byte(8'h01, 3); send_byte(8'h00, 3); send_byte(8'h00, 3); send_byte(8'h00, 3);
    send_byte(8'h02, 3); send_byte(8'h00, 3); send_byte(8'h00, 3); send_byte(8'h00, 0);
    get_tx(0, b, w, h);
    n_tests++; if (b !== 8'h15 || w !== 0) begin n_fail++; $display("FAIL addr_misaligned: got %h after %0d want 15 after 0", b, w); end
    n_tests++; if (req_cycles !== 0 || boot_err_o !== 1'b1) begin n_fail++; $display("FAIL lenaddr_nobus: req cycles %0d err %b want 0 1", req_cycles, boot_err_o); end
    // LEN exactly MAX_WORDS is accepted and moves on to ADDR
    do_reset();
    send_byte(8'hA5, 3); send_byte(8'h00, 3); send_byte(8'h00, 3); send_byte(8'h02, 3); send_byte(8'h00, 3);
    for (int i = 0; i < 4; i++) send_byte(8'h00, 3);
    repeat (4) @(negedge clk_i);
    n_tests++; if (tx_valid_o !== 1'b0 || boot_err_o !== 1'b0) begin n_fail++; $display("FAIL len_max_ok: txv %b err %b want 0 0", tx_valid_o, boot_err_o); end
  endtask

  task automatic test_gnt_wait_skid();
    logic [7:0] b; int w; bit h;
    do_reset();
    gnt_delay = 5;
    send_frame(32'd2, 32'h0000_1000, 8, PL8, CSUM_OK, 3, 1'b1);
    get_tx(2, b, w, h);
    n_tests++; if (b !== 8'h06 || h !== 1'b1) begin n_fail++; $display("FAIL skid_tx: got %h held %b want 06 1", b, h); end
    n_tests++; if (stable_bad !== 0 || last_req_len !== 6) begin n_fail++; $display("FAIL skid_stable: unstable %0d len %0d want 0 6", stable_bad, last_req_len); end
    n_tests++; if (wr_data[0] !== 32'h4433_2211 || wr_data[1] !== 32'h8877_6655 || wr_addr[1] !== 32'h0000_1004) begin n_fail++; $display("FAIL skid_data: got %h %h@%h want 44332211 88776655@00001004", wr_data[0], wr_data[1], wr_addr[1]); end
  endtask

  task automatic test_overrun();
    logic [7:0] b; int w; bit h;
    do_reset();
    gnt_delay = 5;
    send_frame(32'd2, 32'h0000_1000, 6, PL8, 8'h00, 1, 1'b0);
    get_tx(0, b, w, h);
    n_tests++; if (b !== 8'h15) begin n_fail++; $display("FAIL overrun_tx: got %h want 15", b); end
    n_tests++; if (wr_n !== 1 || boot_err_o !== 1'b1) begin n_fail++; $display("FAIL overrun_state: wr_n %0d err %b want 1 1", wr_n, boot_err_o); end
  endtask

  task automatic test_zero_len();
    logic [7:0] b; int w; bit h;
    do_reset();
    gnt_delay = 1;
    send_byte(8'h00, 3); send_byte(8'hFF, 3); send_byte(8'hA5, 3);
    for (int i = 0; i < 4; i++) send_byte(8'h00, 3);
    send_byte(8'h00, 0);
    get_tx(0, b, w, h);
    n_tests++; if (b !== 8'h06) begin n_fail++; $display("FAIL zero_len_tx: got %h want 06", b); end
    n_tests++; if (req_cycles !== 0 || boot_done_o !== 1'b1) begin n_fail++; $display("FAIL zero_len_bus: req cycles %0d done %b want 0 1", req_cycles, boot_done_o); end
  endtask

  task automatic test_reset_mid_write();
    logic [7:0] b; int w; bit h;
    do_reset();
    gnt_delay = 20;
    send_frame(32'd1, 32'h0000_0100, 4, 64'hDDCCBBAA, 8'h00, 0, 1'b0);
    @(negedge clk_i);
    n_tests++; if (bus_req_o !== 1'b1 || bus_data_o !== 32'hDDCC_BBAA) begin n_fail++; $display("FAIL mid_req_pending: req %b data %h want 1 ddccbbaa", bus_req_o, bus_data_o); end
    #2 rst_i = 1'b1;
    #1;
    n_tests++; if (bus_req_o !== 1'b0) begin n_fail++; $display("FAIL mid_async_drop: req %b want 0", bus_req_o); end
    test_reset();
    @(negedge clk_i);
    rst_i = 1'b0;
    clear_mon();
    gnt_delay = 1;
    @(negedge clk_i);
    send_frame(32'd1, 32'h0000_0200, 4, 64'hEFBEADDE, 8'h22, 3, 1'b1);
    get_tx(0, b, w, h);
    n_tests++; if (b !== 8'h06 || wr_n !== 1) begin n_fail++; $display("FAIL after_reset_tx: got %h wr_n %0d want 06 1", b, wr_n); end
    n_tests++; if (wr_data[0] !== 32'hEFBE_ADDE || wr_addr[0] !== 32'h0000_0200) begin n_fail++; $display("FAIL after_reset_wr: got %h@%h want efbeadde@00000200", wr_data[0], wr_addr[0]); end
  endtask

  initial begin
    repeat (3) @(negedge clk_i);
    test_reset();
    rst_i = 1'b0;
    @(negedge clk_i);
    test_basic_load();
    test_bad_csum();
    test_len_addr_errors();
    test_gnt_wait_skid();
    test_overrun();
    test_zero_len();
    test_reset_mid_write();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
